mux_scan: RTL and testbench
===========================

Name: mux_scan

Overview:
- Parametrised, registered N-channel, W-bit channel selector. It is the next generation of the team's 16:1 bit mux.
- Supports two modes:
  - Manual: sel-driven, as before.
  - Auto-scan: round-robin sweep with a programmable dwell per channel.
- Output is registered and carries the channel tag, a sample strobe and a wrap pulse.
- Feeds downstream samplers and monitors that consume one channel at a time.

Parameters:
- N, 16, number of input channels (2..256).
- W, 1, bits per channel.
- SELW, 4, channel index width, must be ≥ ceil(log2(N)).
- DWELLW, 8, dwell counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- i  in  N*W  packed channels; channel k occupies i[k*W +: W].
- en  in  1  block enable; 0 = idle.
- mode  in  1  0 = manual, 1 = scan.
- sel  in  SELW  channel index, used when sel_load=1.
- sel_load  in  1  load sel into the current channel, cur.
- dwell  in  DWELLW  scan dwell; each channel is held dwell+1 cycles.
- y  out  W  registered selected data.
- y_ch  out  SELW  channel index that y belongs to.
- y_valid  out  1  sample strobe.
- wrap  out  1  one-cycle pulse at the end of the last channel's dwell in scan mode.

Behaviour:
- Reset (async assert, sync release):
  - y=0, y_ch=0, y_valid=0, wrap=0.
  - cur=0, cnt=0, dwell_q=0, state=IDLE.
- FSM states: IDLE, MANUAL, SCAN. Evaluated every clock:
  - en=0 → IDLE.
  - en=1 and mode=0 → MANUAL.
  - en=1 and mode=1 → SCAN.
- Datapath latency: 1 cycle. In MANUAL/SCAN, y at edge t+1 = i[cur] sampled at edge t, and y_ch = cur.
- IDLE:
  - y and y_ch hold their values.
  - y_valid=0, wrap=0, cnt cleared to 0.
  - cur holds; sel_load is still honoured.
- sel_load with sel < N: cur <= sel at the next edge, cnt <= 0, dwell_q <= dwell.
- sel_load with sel ≥ N: ignored; cur and cnt unchanged.
- MANUAL:
  - cur changes only on sel_load.
  - y_valid=1 on every cycle y is updated.
  - wrap=0.
- SCAN:
  - dwell_q is latched from dwell on entry to each channel (state entry, advance, or sel_load). A dwell change mid-channel takes effect at the next channel.
  - cnt increments each cycle from 0 up to dwell_q.
  - When cnt==dwell_q:
    - y_valid=1 for that cycle's output.
    - cur advances: cur==N-1 → 0, else cur+1.
    - cnt <= 0.
  - When the advance is from N-1: wrap=1, coincident with that y_valid.
  - Otherwise y_valid=0 and wrap=0; y still tracks i[cur] every cycle.
  - dwell=0 → advance every cycle, with y_valid continuously 1.
- Mode changes:
  - MANUAL→SCAN: scan starts at the current cur with cnt=0.
  - SCAN→MANUAL: cur freezes at its current value and cnt is cleared.
- Simultaneous sel_load and scan advance: sel_load wins. cur=sel, no wrap, and y_valid still reflects the completed dwell.
- Reset mid-scan: all state returns to reset values immediately; the scan restarts from channel 0 after release.
- Non-power-of-two N: indices ≥ N are never generated internally.

Test Plan:
- Reset, then manual select, N=16, W=1:
  - Stimulus: i=16'hA5C3, en=1, mode=0, sel_load sel=4'd5.
  - Required: one cycle after load, y=i[5]=0, y_ch=5, y_valid=1.
  - Then sel=4'd15: y=1, y_ch=15.
- Scan with dwell=2, N=4, W=8:
  - Stimulus: i={8'h44,8'h33,8'h22,8'h11}, en=1, mode=1.
  - Required: y_ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0.
  - y_valid pulses on the third cycle of each channel (y=11,22,33,44).
  - wrap=1 only alongside the y=44 strobe.
- Scan with dwell=0, N=4: y_ch cycles 0,1,2,3,0 on consecutive cycles; y_valid stays 1; wrap pulses every 4th cycle.
- Out-of-range and priority, N=12:
  - sel_load sel=4'd13 → cur unchanged, no y glitch.
  - sel_load sel=4'd7 on the cycle an advance from 11 is due → y_ch=7 next, wrap=0.
- Enable and reset mid-scan:
  - Stimulus: en dropped at cnt=1 on ch2, then re-raised.
  - Required: y_valid=0 and y held while en=0; on re-raise the dwell restarts on ch2 with a full dwell+1 cycles.
  - Stimulus: assert rst_n=0 mid-cycle.
  - Required: y, y_ch, y_valid, wrap go to 0 without waiting for clk.
- Mode flip:
  - SCAN on ch3 → MANUAL: y_ch stays 3 with y_valid=1 every cycle.
  - Back to SCAN: ch3 receives a full dwell before advancing to ch4.

Source files
------------

// File: rtl/mux_scan.sv
// mux_scan: registered N-channel, W-bit channel selector with manual select and
// round-robin auto-scan. Output carries the channel tag, a sample strobe and a
// wrap pulse at the end of the last channel's dwell.
module mux_scan #(
  parameter int unsigned N      = 16,
  parameter int unsigned W      = 1,
  parameter int unsigned SELW   = 4,
  parameter int unsigned DWELLW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N*W-1:0]    i,
  input  logic              en,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic              sel_load,
  input  logic [DWELLW-1:0] dwell,
  output logic [W-1:0]      y,
  output logic [SELW-1:0]   y_ch,
  output logic              y_valid,
  output logic              wrap
);

  // One extra bit so N == 2**SELW still compares correctly.
  localparam logic [SELW:0]   NumCh  = (SELW + 1)'(N);
  localparam logic [SELW-1:0] LastCh = SELW'(N - 1);

  typedef enum logic [1:0] {StIdle, StManual, StScan} state_e;

  state_e state_q, state_d;

  logic [SELW-1:0]   cur_q, cur_d;
  logic [DWELLW-1:0] cnt_q, cnt_d;
  logic [DWELLW-1:0] dwell_q, dwell_d;
  logic [W-1:0]      y_d;
  logic [SELW-1:0]   y_ch_d;
  logic              y_valid_d, wrap_d;

  logic [W-1:0]      ch_data;
  logic              sel_ok;
  logic              scan_entry;
  logic [DWELLW-1:0] dwell_eff;
  logic [DWELLW-1:0] cnt_eff;
  logic              done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows en/mode directly every cycle.
  always_comb begin
    state_d = StIdle;
    if (en) begin
      state_d = mode ? StScan : StManual;
    end
  end

  // Channel mux; indices >= N fall through to zero and are never selected anyway.
  always_comb begin
    ch_data = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (cur_q == SELW'(k)) begin
        ch_data = i[k*W +: W];
      end
    end
  end

  assign sel_ok     = sel_load && ({1'b0, sel} < NumCh);
  // Entering scan uses the live dwell for the first channel.
  assign scan_entry = (state_d == StScan) && (state_q != StScan);
  assign dwell_eff  = scan_entry ? dwell : dwell_q;
  assign cnt_eff    = scan_entry ? '0 : cnt_q;
  assign done       = (cnt_eff == dwell_eff);

  // Output / datapath next-state logic.
  always_comb begin
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    dwell_d   = dwell_q;
    y_d       = y;
    y_ch_d    = y_ch;
    y_valid_d = 1'b0;
    wrap_d    = 1'b0;
    unique case (state_d)
      StIdle: begin
        cnt_d = '0;
      end
      StManual: begin
        y_d       = ch_data;
        y_ch_d    = cur_q;
        y_valid_d = 1'b1;
        cnt_d     = '0;
      end
      StScan: begin
        y_d       = ch_data;
        y_ch_d    = cur_q;
        y_valid_d = done;
        dwell_d   = dwell_eff;
        if (done) begin
          cur_d   = (cur_q == LastCh) ? '0 : cur_q + SELW'(1);
          cnt_d   = '0;
          dwell_d = dwell;
          wrap_d  = (cur_q == LastCh);
        end else begin
          cnt_d = cnt_eff + DWELLW'(1);
        end
      end
      default: ;
    endcase
    // A valid load overrides any scan advance but leaves the strobe intact.
    if (sel_ok) begin
      cur_d   = sel;
      cnt_d   = '0;
      dwell_d = dwell;
      wrap_d  = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      y       <= y_d;
      y_ch    <= y_ch_d;
      y_valid <= y_valid_d;
      wrap    <= wrap_d;
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: three instances (N=16/W=1, N=4/W=8, N=12/W=4) sharing controls.
module tb_mux_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, mode, sel_load;
  logic [3:0]  sel;
  logic [7:0]  dwell;

  logic [15:0] i_a;
  logic [31:0] i_b;
  logic [47:0] i_c;

  logic [0:0]  y_a;
  logic [3:0]  ych_a;
  logic        v_a, w_a;
  logic [7:0]  y_b;
  logic [1:0]  ych_b;
  logic        v_b, w_b;
  logic [3:0]  y_c;
  logic [3:0]  ych_c;
  logic        v_c, w_c;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_scan #(.N(16), .W(1), .SELW(4), .DWELLW(8)) u_a (
    .clk(clk), .rst_n(rst_n), .i(i_a), .en(en), .mode(mode), .sel(sel),
    .sel_load(sel_load), .dwell(dwell), .y(y_a), .y_ch(ych_a), .y_valid(v_a), .wrap(w_a)
  );

  mux_scan #(.N(4), .W(8), .SELW(2), .DWELLW(8)) u_b (
    .clk(clk), .rst_n(rst_n), .i(i_b), .en(en), .mode(mode), .sel(sel[1:0]),
    .sel_load(sel_load), .dwell(dwell), .y(y_b), .y_ch(ych_b), .y_valid(v_b), .wrap(w_b)
  );

  mux_scan #(.N(12), .W(4), .SELW(4), .DWELLW(8)) u_c (
    .clk(clk), .rst_n(rst_n), .i(i_c), .en(en), .mode(mode), .sel(sel),
    .sel_load(sel_load), .dwell(dwell), .y(y_c), .y_ch(ych_c), .y_valid(v_c), .wrap(w_c)
  );

  typedef struct {
    logic       load;
    logic [3:0] sel;
    logic [0:0] y;
    logic [3:0] ch;
    logic       v;
  } man_vec_t;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] y;
    logic       v;
    logic       w;
  } scan_vec_t;

  man_vec_t  mv[10];
  scan_vec_t sv[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel_load = 1'b0; sel = '0; dwell = '0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_mv(input int k, input logic ld, input logic [3:0] s, input logic yy,
                        input logic [3:0] c);
    mv[k].load = ld; mv[k].sel = s; mv[k].y = yy; mv[k].ch = c; mv[k].v = 1'b1;
  endtask

  task automatic set_sv(input int k, input logic [1:0] c, input logic [7:0] yy, input logic v,
                        input logic w);
    sv[k].ch = c; sv[k].y = yy; sv[k].v = v; sv[k].w = w;
  endtask

  initial begin
    // Manual table, i_a = A5C3: bits 0..15 = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
    set_mv(0, 1, 4'd5,  1'b1, 4'd0);
    set_mv(1, 0, 4'd0,  1'b0, 4'd5);
    set_mv(2, 1, 4'd15, 1'b0, 4'd5);
    set_mv(3, 0, 4'd0,  1'b1, 4'd15);
    set_mv(4, 1, 4'd10, 1'b1, 4'd15);
    set_mv(5, 0, 4'd0,  1'b1, 4'd10);
    set_mv(6, 1, 4'd2,  1'b1, 4'd10);
    set_mv(7, 0, 4'd0,  1'b0, 4'd2);
    set_mv(8, 1, 4'd9,  1'b0, 4'd2);
    set_mv(9, 0, 4'd0,  1'b0, 4'd9);
    // Scan table, dwell=2.
    set_sv(0,  2'd0, 8'h11, 0, 0);
    set_sv(1,  2'd0, 8'h11, 0, 0);
    set_sv(2,  2'd0, 8'h11, 1, 0);
    set_sv(3,  2'd1, 8'h22, 0, 0);
    set_sv(4,  2'd1, 8'h22, 0, 0);
    set_sv(5,  2'd1, 8'h22, 1, 0);
    set_sv(6,  2'd2, 8'h33, 0, 0);
    set_sv(7,  2'd2, 8'h33, 0, 0);
    set_sv(8,  2'd2, 8'h33, 1, 0);
    set_sv(9,  2'd3, 8'h44, 0, 0);
    set_sv(10, 2'd3, 8'h44, 0, 0);
    set_sv(11, 2'd3, 8'h44, 1, 1);
    set_sv(12, 2'd0, 8'h11, 0, 0);

    i_a = 16'hA5C3;
    i_b = {8'h44, 8'h33, 8'h22, 8'h11};
    // Channel k of u_c carries 15-k.
    for (int k = 0; k < 12; k++) i_c[k*4 +: 4] = 4'(15 - k);

    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel_load = 1'b0; sel = '0; dwell = '0;
    #2;
    chk("reset_y", 32'(y_a), 0);
    chk("reset_ych", 32'(ych_a), 0);
    chk("reset_valid", 32'(v_a), 0);
    chk("reset_wrap", 32'(w_a), 0);
    #1;
    rst_n = 1'b1;

    // Manual select on N=16.
    en = 1'b1; mode = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sel_load = mv[k].load; sel = mv[k].sel;
      tick();
      chk($sformatf("man%0d_y", k), 32'(y_a), 32'(mv[k].y));
      chk($sformatf("man%0d_ch", k), 32'(ych_a), 32'(mv[k].ch));
      chk($sformatf("man%0d_v", k), 32'(v_a), 32'(mv[k].v));
      chk($sformatf("man%0d_w", k), 32'(w_a), 0);
    end

    // Scan dwell=2 on N=4.
    do_reset();
    en = 1'b1; mode = 1'b1; dwell = 8'd2;
    for (int k = 0; k < 13; k++) begin
      tick();
      chk($sformatf("scan%0d_ch", k), 32'(ych_b), 32'(sv[k].ch));
      chk($sformatf("scan%0d_y", k), 32'(y_b), 32'(sv[k].y));
      chk($sformatf("scan%0d_v", k), 32'(v_b), 32'(sv[k].v));
      chk($sformatf("scan%0d_w", k), 32'(w_b), 32'(sv[k].w));
    end

    // Scan dwell=0 on N=4: one channel per cycle, wrap every 4th.
    do_reset();
    en = 1'b1; mode = 1'b1; dwell = 8'd0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("d0_%0d_ch", k), 32'(ych_b), 32'(k % 4));
      chk($sformatf("d0_%0d_v", k), 32'(v_b), 1);
      chk($sformatf("d0_%0d_w", k), 32'(w_b), (k % 4 == 3) ? 1 : 0);
    end

    // Out-of-range load on N=12.
    do_reset();
    en = 1'b1; mode = 1'b0;
    sel_load = 1'b1; sel = 4'd3; tick();
    sel_load = 1'b0; tick();
    chk("oor_pre_ch", 32'(ych_c), 3);
    sel_load = 1'b1; sel = 4'd13; tick();
    chk("oor_ch0", 32'(ych_c), 3);
    chk("oor_y0", 32'(y_c), 12);
    sel_load = 1'b0; tick();
    chk("oor_ch1", 32'(ych_c), 3);
    chk("oor_y1", 32'(y_c), 12);

    // Load coincident with advance from channel 11: load wins, no wrap.
    sel_load = 1'b1; sel = 4'd11; tick();
    sel_load = 1'b0; tick();
    mode = 1'b1; dwell = 8'd1; tick();
    chk("pri_entry_ch", 32'(ych_c), 11);
    chk("pri_entry_v", 32'(v_c), 0);
    sel_load = 1'b1; sel = 4'd7; tick();
    chk("pri_done_v", 32'(v_c), 1);
    chk("pri_done_w", 32'(w_c), 0);
    chk("pri_done_ch", 32'(ych_c), 11);
    sel_load = 1'b0; tick();
    chk("pri_next_ch", 32'(ych_c), 7);
    chk("pri_next_y", 32'(y_c), 8);
    chk("pri_next_w", 32'(w_c), 0);

    // Enable drop at cnt=1 on ch2, dwell=2.
    do_reset();
    en = 1'b1; mode = 1'b1; dwell = 8'd2;
    repeat (7) tick();
    chk("en_pre_ch", 32'(ych_c), 2);
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("en_idle%0d_v", k), 32'(v_c), 0);
      chk($sformatf("en_idle%0d_y", k), 32'(y_c), 13);
      chk($sformatf("en_idle%0d_ch", k), 32'(ych_c), 2);
    end
    en = 1'b1;
    tick(); chk("en_re0_v", 32'(v_c), 0); chk("en_re0_ch", 32'(ych_c), 2);
    tick(); chk("en_re1_v", 32'(v_c), 0); chk("en_re1_ch", 32'(ych_c), 2);
    tick(); chk("en_re2_v", 32'(v_c), 1); chk("en_re2_ch", 32'(ych_c), 2);
    tick(); chk("en_re3_ch", 32'(ych_c), 3); chk("en_re3_y", 32'(y_c), 12);

    // Asynchronous reset away from the clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_y", 32'(y_c), 0);
    chk("arst_ch", 32'(ych_c), 0);
    chk("arst_v", 32'(v_c), 0);
    chk("arst_w", 32'(w_c), 0);
    #1;
    rst_n = 1'b1;

    // Mode flip: scan dwell=1 to ch3, then manual, then back to scan.
    en = 1'b1; mode = 1'b1; dwell = 8'd1;
    tick();
    chk("flip_restart_ch", 32'(ych_c), 0);
    repeat (6) tick();
    chk("flip_ch3", 32'(ych_c), 3);
    mode = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("flip_man%0d_ch", k), 32'(ych_c), 3);
      chk($sformatf("flip_man%0d_v", k), 32'(v_c), 1);
    end
    mode = 1'b1;
    tick(); chk("flip_scan0_ch", 32'(ych_c), 3); chk("flip_scan0_v", 32'(v_c), 0);
    tick(); chk("flip_scan1_ch", 32'(ych_c), 3); chk("flip_scan1_v", 32'(v_c), 1);
    tick(); chk("flip_scan2_ch", 32'(ych_c), 4); chk("flip_scan2_y", 32'(y_c), 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
